// File: rtl/vga_banner_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_banner_engine_if
// Brief    : Pixel, colour, control and bitmap-write bundle for the banner.
// Revision : 1.0
// ============================================================================
interface vga_banner_engine_if #(
  parameter int BMP_W = 256,
  parameter int BMP_H = 64
);
  localparam int AW = (BMP_H > 1) ? $clog2(BMP_H) : 1;

  logic [9:0]       pix_x;
  logic [9:0]       pix_y;
  logic [15:0]      fg_color;
  logic [15:0]      bg_color;
  logic             bg_transparent;
  logic             move_en;
  logic [3:0]       speed;
  logic             blink_en;
  logic             bmp_we;
  logic [AW-1:0]    bmp_waddr;
  logic [BMP_W-1:0] bmp_wdata;
  logic [15:0]      pix_data;
  logic [9:0]       org_x;
  logic [9:0]       org_y;

  modport master (
    output pix_x, pix_y, fg_color, bg_color, bg_transparent, move_en, speed,
           blink_en, bmp_we, bmp_waddr, bmp_wdata,
    input  pix_data, org_x, org_y
  );

  modport slave (
    input  pix_x, pix_y, fg_color, bg_color, bg_transparent, move_en, speed,
           blink_en, bmp_we, bmp_waddr, bmp_wdata,
    output pix_data, org_x, org_y
  );
endinterface
`default_nettype wire

// File: rtl/vga_banner_engine.sv
`default_nettype none
// ============================================================================
// Module   : vga_banner_engine
// Brief    : Scaled, bouncing, blinking monochrome bitmap banner for VGA.
// Revision : 1.0
// ============================================================================
module vga_banner_engine #(
  parameter int          H_RES        = 640,
  parameter int          V_RES        = 480,
  parameter int          BMP_W        = 256,
  parameter int          BMP_H        = 64,
  parameter int          SCALE_LOG2   = 0,
  parameter int          STEP         = 2,
  parameter int          INIT_X       = 192,
  parameter int          INIT_Y       = 208,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [15:0] BACK_COLOR   = 16'h0000
) (
  input  logic               vga_clk,
  input  logic               sys_rst,
  vga_banner_engine_if.slave bus
);
  localparam int WD = BMP_W << SCALE_LOG2;
  localparam int HD = BMP_H << SCALE_LOG2;
  localparam int AW = (BMP_H > 1) ? $clog2(BMP_H) : 1;
  localparam int CW = (BMP_W > 1) ? $clog2(BMP_W) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] COL_MSB = CW'(BMP_W - 1);

  generate
    if (WD > H_RES || HD > V_RES || INIT_X + WD > H_RES || INIT_Y + HD > V_RES ||
        SCALE_LOG2 < 0 || SCALE_LOG2 > 2) begin : g_bad_params
      $error("vga_banner_engine: banner geometry does not fit the screen");
    end
  endgenerate

  typedef enum logic [0:0] {X_RIGHT = 1'b0, X_LEFT = 1'b1} xdir_t;
  typedef enum logic [0:0] {Y_DOWN  = 1'b0, Y_UP   = 1'b1} ydir_t;

  xdir_t            xdir_q;
  ydir_t            ydir_q;
  logic [9:0]       org_x_q, org_y_q;
  logic [3:0]       cnt_q;
  logic [BW-1:0]    blink_cnt_q;
  logic             blank_q;
  logic [BMP_W-1:0] mem_q [BMP_H];

  logic             hit_q, hit_d;
  logic [CW-1:0]    col_q, col_d;
  logic [AW-1:0]    row_q, row_d;
  logic [15:0]      fg_q, bg_q, pix_q, pix_d;
  logic             transp_q;

  logic             tick, step, bit_on;
  logic [10:0]      dx, dy;
  logic [BMP_W-1:0] row_bits;

  assign tick = (bus.pix_x == 10'(H_RES - 1)) && (bus.pix_y == 10'(V_RES - 1));
  assign step = bus.move_en && tick && (cnt_q == bus.speed);

  always_ff @(posedge vga_clk) begin
    if (bus.bmp_we && (int'(bus.bmp_waddr) < BMP_H))
      mem_q[bus.bmp_waddr] <= bus.bmp_wdata;
  end

  // Stage 1: box hit and scaled bitmap coordinates.
  assign dx    = {1'b0, bus.pix_x} - {1'b0, org_x_q};
  assign dy    = {1'b0, bus.pix_y} - {1'b0, org_y_q};
  assign hit_d = (bus.pix_x >= org_x_q) && (dx < 11'(WD)) &&
                 (bus.pix_y >= org_y_q) && (dy < 11'(HD));
  assign col_d = hit_d ? CW'(dx >> SCALE_LOG2) : '0;
  assign row_d = hit_d ? AW'(dy >> SCALE_LOG2) : '0;

  // Stage 2: bitmap lookup; a same-cycle write to this row is not yet visible.
  assign row_bits = mem_q[row_q];
  assign bit_on   = row_bits[COL_MSB - col_q];

  always_comb begin
    pix_d = BACK_COLOR;
    if (hit_q && !blank_q) begin
      if (bit_on)
        pix_d = fg_q;
      else if (!transp_q)
        pix_d = bg_q;
    end
  end

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hit_q    <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      fg_q     <= '0;
      bg_q     <= '0;
      transp_q <= 1'b0;
      pix_q    <= BACK_COLOR;
    end else begin
      hit_q    <= hit_d;
      col_q    <= col_d;
      row_q    <= row_d;
      fg_q     <= bus.fg_color;
      bg_q     <= bus.bg_color;
      transp_q <= bus.bg_transparent;
      pix_q    <= pix_d;
    end
  end

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q       <= '0;
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
    end else begin
      if (!bus.move_en)
        cnt_q <= '0;
      else if (tick)
        cnt_q <= (cnt_q == bus.speed) ? 4'd0 : cnt_q + 4'd1;

      if (!bus.blink_en) begin
        blink_cnt_q <= '0;
        blank_q     <= 1'b0;
      end else if (tick) begin
        if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt_q <= '0;
          blank_q     <= ~blank_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
      end
    end
  end

  // Bounce: each axis overshooting an edge is clamped to it and reverses.
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      xdir_q  <= X_RIGHT;
      ydir_q  <= Y_DOWN;
      org_x_q <= 10'(INIT_X);
      org_y_q <= 10'(INIT_Y);
    end else if (step) begin
      case (xdir_q)
        X_RIGHT:
          if (int'(org_x_q) + WD + STEP <= H_RES) begin
            org_x_q <= org_x_q + 10'(STEP);
          end else begin
            org_x_q <= 10'(H_RES - WD);
            xdir_q  <= X_LEFT;
          end
        X_LEFT:
          if (int'(org_x_q) >= STEP) begin
            org_x_q <= org_x_q - 10'(STEP);
          end else begin
            org_x_q <= '0;
            xdir_q  <= X_RIGHT;
          end
      endcase
      case (ydir_q)
        Y_DOWN:
          if (int'(org_y_q) + HD + STEP <= V_RES) begin
            org_y_q <= org_y_q + 10'(STEP);
          end else begin
            org_y_q <= 10'(V_RES - HD);
            ydir_q  <= Y_UP;
          end
        Y_UP:
          if (int'(org_y_q) >= STEP) begin
            org_y_q <= org_y_q - 10'(STEP);
          end else begin
            org_y_q <= '0;
            ydir_q  <= Y_DOWN;
          end
      endcase
    end
  end

  assign bus.pix_data = pix_q;
  assign bus.org_x    = org_x_q;
  assign bus.org_y    = org_y_q;
endmodule
`default_nettype wire
